// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: 8-deep, 12-bit first-word-fall-through FIFO built on a
// single-clock true dual-port RAM. Port A writes and port B reads. A small
// bypass register hides the RAM's registered read latency and its old-data
// read-during-write behaviour.

// true_dpram_sclk: single-clock true dual-port RAM with registered read data.
// When a port reads the address being written on the same edge, it returns
// the old contents.
module true_dpram_sclk #(
  parameter int DW = 12,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  output logic [DW-1:0] q_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] mem [2**AW];

  // Both ports share one process, so the array has a single driver. The
  // reads sample the array before this edge's writes land, which gives
  // old-data read-during-write behaviour.
  // NOTE: the storage array has no reset. Clearing it would turn the RAM into
  // a flop array. Stale contents are never visible because the controller
  // tracks occupancy.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

endmodule

module dpram_fifo_ctrl #(
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [11:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  count,
  output logic        full,
  output logic        empty,
  output logic        almost_full,
  output logic        almost_empty
);

  // Each pointer is a 3-bit RAM address plus a wrap bit. Equal pointers mean
  // the FIFO is empty. Equal addresses with different wrap bits mean it is full.
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic [3:0]  rd_ptr_next;
  logic [2:0]  addr_b;
  logic        push;
  logic        pop;
  logic        byp_sel;
  logic [11:0] byp_data;
  logic [11:0] q_b;
  logic [11:0] q_a_unused;

  // Status decodes of the registered occupancy count.
  assign full         = (count == 4'd8);
  assign empty        = (count == 4'd0);
  assign almost_full  = (count >= 4'(AF_LEVEL));
  assign almost_empty = (count <= 4'(AE_LEVEL));

  // in_ready does not depend on out_ready, so a full FIFO refuses a write even
  // in a cycle where it is also popped.
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Port B always fetches the word that will be at the head after this edge.
  // q_b then presents the new head in the next cycle without a bubble.
  assign rd_ptr_next = rd_ptr + {3'b000, pop};
  assign addr_b      = rd_ptr_next[2:0];

  // When a write lands on the address port B reads, the RAM returns old data.
  // The word just written is taken from the bypass register instead.
  assign out_data = byp_sel ? byp_data : q_b;

  true_dpram_sclk #(
    .DW(12),
    .AW(3)
  ) u_ram (
    .clk   (clk),
    .we_a  (push),
    .addr_a(wr_ptr[2:0]),
    .data_a(in_data),
    .q_a   (q_a_unused),
    .we_b  (1'b0),
    .addr_b(addr_b),
    .data_b(12'h000),
    .q_b   (q_b)
  );

  // Pointer, occupancy and bypass-select state. Reset and flush take priority
  // over push and pop.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // updates from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= 4'd0;
      rd_ptr  <= 4'd0;
      count   <= 4'd0;
      byp_sel <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr_next;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      byp_sel <= push && (wr_ptr[2:0] == addr_b);
    end
  end

  // The bypass data register needs no reset. It is only read while byp_sel is
  // set, and byp_sel is only set by a push that also loads this register.
  always_ff @(posedge clk) begin
    if (push) byp_data <= in_data;
  end

  // The pointer view of occupancy must always agree with the count register.
  a_count_ptr : assert property (@(posedge clk) disable iff (reset)
    count == (wr_ptr - rd_ptr));
  a_empty_ptr : assert property (@(posedge clk) disable iff (reset)
    empty == (wr_ptr == rd_ptr));
  a_full_ptr  : assert property (@(posedge clk) disable iff (reset)
    full == ((wr_ptr[2:0] == rd_ptr[2:0]) && (wr_ptr[3] != rd_ptr[3])));
  a_no_ovf    : assert property (@(posedge clk) disable iff (reset)
    !(push && full));
  a_no_unf    : assert property (@(posedge clk) disable iff (reset)
    !(pop && empty));

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl. The reference model is a plain queue of words:
// a word is accepted when in_valid is high, fewer than 8 words are held and
// flush is low. A word is removed when out_ready is high and the queue is
// non-empty. Reset and flush empty the queue.
module tb_dpram_fifo_ctrl;

  localparam int AF = 6;
  localparam int AE = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;

  int checks = 0;
  int errors = 0;
  logic [11:0] model_q[$];

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  // Apply inputs for one clock cycle and advance the reference model across
  // the rising edge. The task returns at the following falling edge, where
  // the outputs are stable.
  task automatic drive(input logic v, input logic [11:0] d, input logic r, input logic f);
    bit do_push;
    bit do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    do_push = v && (model_q.size() < 8) && !f;
    do_pop  = r && (model_q.size() > 0);
    @(posedge clk);
    if (reset || f) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 12'h000, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0)      begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0)       begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); end
    checks++; if (almost_full !== 1'b0)  begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
  endtask

  // Push 0x001..0x003 without popping, then drain the three words.
  task automatic test_basic();
    logic [11:0] d;
    for (int i = 1; i <= 3; i++) begin
      d = 12'(i);
      drive(1'b1, d, 1'b0, 1'b0);
      checks++; if (count !== 4'(i))      begin errors++; $display("FAIL basic_count: got %0d expected %0d", count, i); end
      checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== 12'h001) begin errors++; $display("FAIL basic_head: got %h expected 001", out_data); end
    end
    for (int i = 1; i <= 3; i++) begin
      d = 12'(i);
      checks++; if (out_data !== d) begin errors++; $display("FAIL basic_drain: got %h expected %h", out_data, d); end
      drive(1'b0, 12'h000, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b expected 1", empty); end
  endtask

  // Fill to 8 words, pop once while in_valid stays high, then drain.
  task automatic test_full();
    logic [11:0] d;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 12'hA00 + 12'(i), 1'b0, 1'b0);
      checks++; if (count !== 4'(i + 1)) begin errors++; $display("FAIL full_count: got %0d expected %0d", count, i + 1); end
      checks++; if (almost_full !== (i + 1 >= AF)) begin errors++; $display("FAIL full_almost_full: got %b at count %0d", almost_full, i + 1); end
      checks++; if (almost_empty !== (i + 1 <= AE)) begin errors++; $display("FAIL full_almost_empty: got %b at count %0d", almost_empty, i + 1); end
    end
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL full_flag: got %b expected 1", full); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_data !== 12'hA00) begin errors++; $display("FAIL full_head: got %h expected a00", out_data); end
    drive(1'b1, 12'hBBB, 1'b1, 1'b0);
    checks++; if (count !== 4'd7)    begin errors++; $display("FAIL full_pop_count: got %0d expected 7", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b expected 1", in_ready); end
    for (int i = 1; i < 8; i++) begin
      d = 12'hA00 + 12'(i);
      checks++; if (out_data !== d) begin errors++; $display("FAIL full_drain: got %h expected %h", out_data, d); end
      drive(1'b0, 12'h000, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty: got %b expected 1", empty); end
  endtask

  // Push and pop every cycle. Each word must appear one cycle after its push.
  task automatic test_streaming();
    logic [11:0] d;
    for (int i = 0; i < 20; i++) begin
      d = 12'h100 + 12'(i);
      drive(1'b1, d, 1'b1, 1'b0);
      checks++; if (count !== 4'd1)    begin errors++; $display("FAIL stream_count: got %0d expected 1", count); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== d)    begin errors++; $display("FAIL stream_data: got %h expected %h", out_data, d); end
    end
    drive(1'b0, 12'h000, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b expected 1", empty); end
  endtask

  // Twelve words through a 3-deep occupancy, starting at address 0, so the
  // pointers wrap past address 7.
  task automatic test_wrap();
    logic [11:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 12'h300 + 12'(i), 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      d = 12'h300 + 12'(k);
      checks++; if (out_data !== d) begin errors++; $display("FAIL wrap_data: got %h expected %h", out_data, d); end
      if (k < 9) begin
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", count); end
        drive(1'b1, 12'h303 + 12'(k), 1'b1, 1'b0);
      end else begin
        drive(1'b0, 12'h000, 1'b1, 1'b0);
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  // Flush at five words with in_valid high, then push a fresh word.
  task automatic test_flush();
    for (int i = 0; i < 5; i++) drive(1'b1, 12'h400 + 12'(i), 1'b0, 1'b0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    drive(1'b1, 12'h7FF, 1'b0, 1'b1);
    checks++; if (count !== 4'd0)     begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    drive(1'b1, 12'h5A5, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL flush_new_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 12'h5A5) begin errors++; $display("FAIL flush_new_data: got %h expected 5a5", out_data); end
    checks++; if (count !== 4'd1)       begin errors++; $display("FAIL flush_new_count: got %0d expected 1", count); end
    drive(1'b0, 12'h000, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_drained: got %b expected 1", empty); end
  endtask

  // Random traffic with phases of varying pop probability, so the FIFO
  // spends time both full and empty. Rare flushes are mixed in.
  task automatic test_random();
    logic        v;
    logic        r;
    logic        f;
    logic [11:0] d;
    int          n;
    int          pop_pct;
    for (int c = 0; c < 10000; c++) begin
      if (c % 400 == 0) pop_pct = int'($urandom_range(10, 90));
      v = ($urandom_range(0, 99) < 60);
      r = (int'($urandom_range(0, 99)) < pop_pct);
      f = ($urandom_range(0, 299) == 0);
      d = 12'($urandom);
      drive(v, d, r, f);
      n = model_q.size();
      checks++; if (count !== 4'(n)) begin errors++; $display("FAIL rnd_count: cycle %0d got %0d expected %0d", c, count, n); end
      checks++; if (out_valid !== (n != 0)) begin errors++; $display("FAIL rnd_valid: cycle %0d got %b expected %b", c, out_valid, n != 0); end
      checks++; if (full !== (n == 8)) begin errors++; $display("FAIL rnd_full: cycle %0d got %b expected %b", c, full, n == 8); end
      checks++; if (empty !== (n == 0)) begin errors++; $display("FAIL rnd_empty: cycle %0d got %b expected %b", c, empty, n == 0); end
      checks++; if (almost_full !== (n >= AF)) begin errors++; $display("FAIL rnd_almost_full: cycle %0d got %b at %0d", c, almost_full, n); end
      checks++; if (almost_empty !== (n <= AE)) begin errors++; $display("FAIL rnd_almost_empty: cycle %0d got %b at %0d", c, almost_empty, n); end
      checks++; if (in_ready !== (n < 8 && !f)) begin errors++; $display("FAIL rnd_in_ready: cycle %0d got %b expected %b", c, in_ready, n < 8 && !f); end
      if (n > 0) begin
        checks++; if (out_data !== model_q[0]) begin errors++; $display("FAIL rnd_data: cycle %0d got %h expected %h", c, out_data, model_q[0]); end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 12'h000;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_streaming();
    test_wrap();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
